// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - word FIFO feeding a UART transmitter through a registered one-shot send handshake
module uart_tx_feeder #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic                     tx_send,
    output logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_ready,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             tx_send_q;
    logic [WIDTH-1:0] tx_data_q;
    state_t           state_q;
    logic             push;
    logic             pop;

    // Push looks only at the registered count, so a same-cycle pop never frees a slot for it.
    always_comb begin
        push       = wr_en && (count_q != FULL_COUNT);
        pop        = (state_q == IDLE) && (count_q != '0) && tx_ready;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= IDLE;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        tx_send_q <= 1'b1;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    tx_send_q <= 1'b0;
                    state_q   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_send_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;
    assign idle     = (count_q == '0) && (state_q == IDLE);

endmodule
